// File: rtl/write_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : write_stage_pkg                                                   |
// | Brief  : Architectural register types shared by the pipeline stages.       |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package write_stage_pkg;

  localparam int NR     = 4;
  localparam int RIDX_W = $clog2(NR);

  typedef logic [4:0]              regind_t;
  typedef logic [31:0]             regval_t;
  typedef logic [NR-1:0][31:0]     regfile_t;

  localparam regfile_t ZeroRegFile = '0;
  localparam regind_t  Flags       = 5'd3;
  localparam regind_t  PC          = 5'd2;
  localparam regind_t  NR_IDX      = regind_t'(NR);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STORE = 1'b1
  } write_state_t;

  // Register 0 and out-of-range indices read as zero.
  function automatic regval_t read_reg(input regfile_t rf, input regind_t d);
    regval_t v;
    v = '0;
    if (d != 5'd0 && d < NR_IDX) v = rf[d[RIDX_W-1:0]];
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/execute_to_write_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : execute_to_write_if                                               |
// | Brief  : Execute-to-write handshake bundle; write stage owns hold.         |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface execute_to_write_if;
  import write_stage_pkg::*;

  regval_t     pc;
  regval_t     adjustment;
  regval_t     destination_value;
  regind_t     destination;
  logic [3:0]  flags;
  logic        destination_is_memory;
  logic        has_flushed;
  logic        is_valid;
  logic        hold;

  modport write_in (
    input  pc, adjustment, destination_value, destination, flags,
           destination_is_memory, has_flushed, is_valid,
    output hold
  );

  modport write_out (
    output pc, adjustment, destination_value, destination, flags,
           destination_is_memory, has_flushed, is_valid,
    input  hold
  );
endinterface
`default_nettype wire

// File: rtl/write_stage_regfile_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : regfile_writer                                                    |
// | Brief  : Next-state register file for one retiring slot.                   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module regfile_writer
  import write_stage_pkg::*;
#(
  parameter int unsigned PC_STEP = 4
) (
  input  regfile_t    cur,
  input  regind_t     dest,
  input  regval_t     value,
  input  logic [3:0]  flags,
  input  regval_t     pc,
  input  logic        is_store,
  output regfile_t    nxt
);

  logic w_reg_write;

  assign w_reg_write = !is_store && (dest != 5'd0) && (dest < NR_IDX);

  always_comb begin
    nxt = cur;
    // Flags and PC always advance; an explicit write to either overrides it.
    if (w_reg_write && dest == Flags) nxt[Flags]      = value;
    else                              nxt[Flags][3:0] = flags;
    if (w_reg_write && dest == PC)    nxt[PC]         = value;
    else                              nxt[PC]         = pc + regval_t'(PC_STEP);
    if (w_reg_write && dest != Flags && dest != PC)
      nxt[dest[RIDX_W-1:0]] = value;
  end

endmodule
`default_nettype wire

// File: rtl/write_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : write_stage                                                       |
// | Brief  : Final stage: retires results, owns regfile, issues stores.        |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module write_stage
  import write_stage_pkg::*;
#(
  parameter int unsigned PC_STEP = 4,
  parameter int unsigned MEM_AW  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  execute_to_write_if.write_in ew,
  output regfile_t          registers,
  output logic              pc_redirect,
  output logic [31:0]       redirect_target,
  output logic [MEM_AW-1:0] mem_address,
  output logic [31:0]       mem_writedata,
  output logic              mem_write,
  input  logic              mem_waitrequest,
  output logic [31:0]       retired_count
);

  write_state_t      r_state;
  regfile_t          r_regs;
  regfile_t          w_next_regs;
  logic              r_pc_redirect;
  regval_t           r_redirect_target;
  logic [MEM_AW-1:0] r_mem_address;
  regval_t           r_mem_writedata;
  logic              r_mem_write;
  logic [31:0]       r_retired_count;
  logic              w_accept;
  regval_t           w_store_sum;

  assign w_accept    = (r_state == IDLE) && ew.is_valid && !ew.has_flushed;
  assign w_store_sum = read_reg(r_regs, ew.destination) + ew.adjustment;
  assign ew.hold     = (r_state == STORE);

  regfile_writer #(.PC_STEP(PC_STEP)) u_regfile_writer (
    .cur      (r_regs),
    .dest     (ew.destination),
    .value    (ew.destination_value),
    .flags    (ew.flags),
    .pc       (ew.pc),
    .is_store (ew.destination_is_memory),
    .nxt      (w_next_regs)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= IDLE;
      r_regs            <= ZeroRegFile;
      r_pc_redirect     <= 1'b0;
      r_redirect_target <= '0;
      r_mem_address     <= '0;
      r_mem_writedata   <= '0;
      r_mem_write       <= 1'b0;
      r_retired_count   <= '0;
    end else begin
      r_pc_redirect <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_regs          <= w_next_regs;
            r_retired_count <= r_retired_count + 32'd1;
            if (ew.destination_is_memory) begin
              r_mem_address   <= w_store_sum[MEM_AW-1:0];
              r_mem_writedata <= ew.destination_value;
              r_mem_write     <= 1'b1;
              r_state         <= STORE;
            end else if (ew.destination == PC) begin
              r_pc_redirect     <= 1'b1;
              r_redirect_target <= ew.destination_value;
            end
          end
        end
        STORE: begin
          if (r_mem_write && !mem_waitrequest) begin
            r_mem_write <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign registers       = r_regs;
  assign pc_redirect     = r_pc_redirect;
  assign redirect_target = r_redirect_target;
  assign mem_address     = r_mem_address;
  assign mem_writedata   = r_mem_writedata;
  assign mem_write       = r_mem_write;
  assign retired_count   = r_retired_count;

endmodule
`default_nettype wire
